// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Number of bit slots in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO with flush; read data is presented combinationally from the read pointer.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Flush wins over anything happening on the same edge.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO, baud down-counter and frame serialiser.
//
//   state     | meaning
//   ST_IDLE   | line high, waiting for a buffered word
//   ST_START  | start bit (low) on the line
//   ST_DATA   | data bits, LSB first
//   ST_PARITY | parity bit
//   ST_STOP   | stop bit(s); may chain straight into the next start bit
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          tx_pause,
    input  logic                          tx_flush,
    output logic                          tx_pin,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);
    localparam logic [3:0]    LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP   = 4'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   pin_q, pin_d;
    logic                   busy_q, busy_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   baud_zero;
    logic                   start_ok;
    logic                   par_load;

    assign tx_ready  = !fifo_full && !tx_flush;
    assign fifo_push = tx_valid && tx_ready;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (tx_flush),
        .din_i   (tx_data),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_zero = (baud_q == '0);
    // A flush in the same cycle suppresses the pop, so no frame is started from stale data.
    assign start_ok  = !fifo_empty && !tx_pause && !tx_flush;
    assign par_load  = (^fifo_dout) ^ (PARITY == PAR_ODD);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_zero ? BAUD_RELOAD : baud_q - 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        pin_d    = pin_q;
        busy_d   = busy_q;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pin_d  = 1'b1;
                busy_d = 1'b0;
                baud_d = BAUD_RELOAD;
                if (start_ok) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    par_d    = par_load;
                    pin_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_zero) begin
                    pin_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_zero) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (PARITY != PAR_NONE) begin
                            pin_d   = par_q;
                            state_d = ST_PARITY;
                        end else begin
                            pin_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        pin_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_zero) begin
                    pin_d   = 1'b1;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_zero) begin
                    if (bit_q == LAST_STOP) begin
                        if (start_ok) begin
                            // Back-to-back: next start bit begins on this very edge.
                            fifo_pop = 1'b1;
                            shift_d  = fifo_dout;
                            par_d    = par_load;
                            pin_d    = 1'b0;
                            state_d  = ST_START;
                        end else begin
                            pin_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                pin_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pin_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pin_q   <= pin_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_pin  = pin_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: three transmitters (8N1, 8E2, 8O1) at CLK_DIV=4, line monitors decode every frame.
module tb_uart_tx_buffered;

    localparam int CD = 4;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data [3];
    logic [2:0] tx_valid;
    logic [2:0] tx_pause;
    logic [2:0] tx_flush;
    wire  [2:0] tx_ready;
    wire  [2:0] tx_pin;
    wire  [2:0] tx_busy;
    wire  [4:0] cnt0;
    wire  [4:0] cnt1;
    wire  [4:0] cnt2;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_buffered #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx_pause(tx_pause[0]), .tx_flush(tx_flush[0]), .tx_pin(tx_pin[0]), .tx_busy(tx_busy[0]),
        .fifo_count(cnt0));

    uart_tx_buffered #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx_pause(tx_pause[1]), .tx_flush(tx_flush[1]), .tx_pin(tx_pin[1]), .tx_busy(tx_busy[1]),
        .fifo_count(cnt1));

    uart_tx_buffered #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .tx_pause(tx_pause[2]), .tx_flush(tx_flush[2]), .tx_pin(tx_pin[2]), .tx_busy(tx_busy[2]),
        .fifo_count(cnt2));

    function automatic int par_cfg(input int idx);
        return (idx == 1) ? 2 : (idx == 2) ? 1 : 0;
    endfunction

    function automatic int stop_cfg(input int idx);
        return (idx == 1) ? 2 : 1;
    endfunction

    function automatic int cnt(input int idx);
        return (idx == 0) ? int'(cnt0) : (idx == 1) ? int'(cnt1) : int'(cnt2);
    endfunction

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input int idx, input logic [7:0] d, input logic par);
        int   n;
        exp_t e;
        n = 0;
        tx_data[idx]  = d;
        tx_valid[idx] = 1'b1;
        #1;
        while (!tx_ready[idx] && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!tx_ready[idx]) begin
            checks++;
            failures++;
            $display("FAIL push_timeout dut%0d: tx_ready stayed 0 for %0d cycles, expected 1", idx, n);
        end else begin
            e.dut  = idx;
            e.data = d;
            e.par  = par;
            exp_q.push_back(e);
            @(posedge clk);
        end
        @(negedge clk);
        tx_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int idx, input int budget, input string name);
        int n;
        n = 0;
        while ((tx_busy[idx] || cnt(idx) != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(name, int'(tx_busy[idx]), 0);
    endtask

    // Checks every cycle of each frame against the waveform expected for the oldest queued word.
    task automatic monitor(input int idx);
        exp_t        e;
        logic [11:0] bits;
        int          nb;
        int          found;
        int          bad_at;
        logic        par_got;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst_n && tx_pin[idx] == 1'b0) begin
                found = -1;
                foreach (exp_q[i]) if (found < 0 && exp_q[i].dut == idx) found = i;
                if (found < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame dut%0d: start bit seen, no word expected", idx);
                    while (rst_n && tx_pin[idx] == 1'b0) @(negedge clk);
                end else begin
                    e = exp_q[found];
                    exp_q.delete(found);
                    bits = '1;
                    bits[0] = 1'b0;
                    for (int b = 0; b < 8; b++) bits[1+b] = e.data[b];
                    nb = 9;
                    if (par_cfg(idx) != 0) begin
                        bits[9] = e.par;
                        nb = 10;
                    end
                    nb += stop_cfg(idx);
                    bad_at  = -1;
                    aborted = 1'b0;
                    par_got = 1'b0;
                    for (int c = 0; c < nb * CD; c++) begin
                        if (c > 0) @(negedge clk);
                        if (!rst_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (bad_at < 0 && tx_pin[idx] !== bits[c / CD]) bad_at = c;
                        if (par_cfg(idx) != 0 && c == 9 * CD + CD / 2) par_got = tx_pin[idx];
                    end
                    if (!aborted) begin
                        check_eq($sformatf("frame_dut%0d_%02h_first_bad_cycle", idx, e.data), bad_at, -1);
                        if (par_cfg(idx) != 0)
                            check_eq($sformatf("parity_dut%0d_%02h", idx, e.data), int'(par_got), int'(e.par));
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int n;
        int peak;
        tx_valid = '0;
        tx_pause = '0;
        tx_flush = '0;
        for (int i = 0; i < 3; i++) tx_data[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pin", int'(tx_pin[0]), 1);
        check_eq("rst_busy", int'(tx_busy[0]), 0);
        check_eq("rst_count", int'(cnt0), 0);
        check_eq("rst_ready", int'(tx_ready[0]), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // single 0x55 frame, 8N1
        push(0, 8'h55, 1'b0);
        check_eq("t1_pin_before_pop", int'(tx_pin[0]), 1);
        @(negedge clk);
        check_eq("t1_start_latency", int'(tx_pin[0]), 0);
        n = 0;
        while (tx_busy[0] && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq("t1_busy_cycles", n, 40);

        // three back-to-back frames
        push(0, 8'hA0, 1'b0);
        t0 = cyc;
        check_eq("t2_count_a", int'(cnt0), 1);
        push(0, 8'h0F, 1'b0);
        check_eq("t2_count_b", int'(cnt0), 1);
        push(0, 8'hFF, 1'b0);
        check_eq("t2_count_c", int'(cnt0), 2);
        peak = 2;
        while (tx_busy[0] && cyc < t0 + 400) begin
            if (int'(cnt0) > peak) peak = int'(cnt0);
            if (cyc == t0 + 40 || cyc == t0 + 80)
                check_eq($sformatf("t2_stop_before_boundary_%0d", cyc - t0), int'(tx_pin[0]), 1);
            if (cyc == t0 + 41 || cyc == t0 + 81)
                check_eq($sformatf("t2_start_at_boundary_%0d", cyc - t0), int'(tx_pin[0]), 0);
            @(negedge clk);
        end
        check_eq("t2_busy_cycles", cyc - (t0 + 1), 120);
        check_eq("t2_peak_count", peak, 2);

        // pause: fill FIFO, 17th word held
        tx_pause[0] = 1'b1;
        for (int i = 0; i < 16; i++) push(0, 8'(8'h30 + i), 1'b0);
        check_eq("t3_count_full", int'(cnt0), 16);
        check_eq("t3_ready_full", int'(tx_ready[0]), 0);
        tx_data[0]  = 8'h7E;
        tx_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t3_ready_held", int'(tx_ready[0]), 0);
        check_eq("t3_count_held", int'(cnt0), 16);
        check_eq("t3_no_tx_paused", int'(tx_busy[0]), 0);
        tx_pause[0] = 1'b0;
        push(0, 8'h7E, 1'b0);
        check_eq("t3_count_after_17th", int'(cnt0), 16);
        wait_idle(0, 1000, "t3_drain");

        // parity variants
        push(2, 8'h03, 1'b1);
        push(1, 8'h03, 1'b0);
        @(negedge clk);
        n = 0;
        while (tx_busy[1] && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq("t4_busy_8e2", n, 48);
        push(1, 8'h07, 1'b1);
        wait_idle(1, 200, "t4_idle_8e2");
        wait_idle(2, 200, "t4_idle_8o1");

        // flush mid-frame with 5 buffered words
        push(0, 8'hC1, 1'b0);
        push(0, 8'hC2, 1'b0);
        push(0, 8'hC3, 1'b0);
        push(0, 8'hC4, 1'b0);
        push(0, 8'hC5, 1'b0);
        push(0, 8'hC6, 1'b0);
        check_eq("t5_count_before", int'(cnt0), 5);
        repeat (4) @(negedge clk);
        check_eq("t5_busy_mid", int'(tx_busy[0]), 1);
        tx_flush[0] = 1'b1;
        #1;
        check_eq("t5_ready_during_flush", int'(tx_ready[0]), 0);
        @(negedge clk);
        tx_flush[0] = 1'b0;
        check_eq("t5_count_after", int'(cnt0), 0);
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].dut == 0) exp_q.delete(i);
        wait_idle(0, 200, "t5_frame_end");
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_pin[0] !== 1'b1 || tx_busy[0] !== 1'b0) n++;
        end
        check_eq("t5_stays_idle", n, 0);

        // async reset mid-frame (inside data bit 0 of 0x5A, which is low)
        push(0, 8'h5A, 1'b0);
        repeat (6) @(negedge clk);
        check_eq("t6_pin_low_before", int'(tx_pin[0]), 0);
        check_eq("t6_busy_before", int'(tx_busy[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_pin_reset", int'(tx_pin[0]), 1);
        check_eq("t6_busy_reset", int'(tx_busy[0]), 0);
        check_eq("t6_count_reset", int'(cnt0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("t6_idle_after_reset", int'(tx_pin[0]), 1);
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
